// File: rtl/lsu_pkg.sv
// Shared types, funct3 encodings and the access-legality rule for the load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    // Unsigned variants exist only for loads; halfwords need even and words 4-byte alignment.
    function automatic logic is_legal(input logic is_store, input logic [2:0] funct3,
                                      input logic [1:0] off);
        logic ok;
        ok = 1'b0;
        case (funct3)
            F3_B:    ok = 1'b1;
            F3_H:    ok = ~off[0];
            F3_W:    ok = (off == 2'b00);
            F3_BU:   ok = ~is_store;
            F3_HU:   ok = ~is_store & ~off[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Core-side request/response and data-memory signals of the load/store unit.
interface lsu_if #(
    parameter int ADDR_W = 32
);
    // req: the unit accepts a request on any clock edge where req_valid && req_ready.
    // mem: mem_req stays high with stable address/data until the edge where mem_ready=1.
    logic              req_valid;
    logic              req_ready;
    logic              req_is_store;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic              resp_err;
    logic [31:0]       load_data;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wmask;
    logic [31:0]       mem_rdata;
    logic              mem_ready;

    modport master (
        output req_valid, req_is_store, req_funct3, req_addr, req_wdata, mem_rdata, mem_ready,
        input  req_ready, resp_valid, resp_err, load_data,
               mem_req, mem_we, mem_addr, mem_wdata, mem_wmask
    );

    modport slave (
        input  req_valid, req_is_store, req_funct3, req_addr, req_wdata, mem_rdata, mem_ready,
        output req_ready, resp_valid, resp_err, load_data,
               mem_req, mem_we, mem_addr, mem_wdata, mem_wmask
    );
endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering: replicates store data into lanes and extracts/extends load data.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] wdata_o,
    output logic [3:0]  wmask_o,
    output logic [31:0] load_o
);
    logic [31:0] shifted;

    assign shifted = rdata_i >> {off_i, 3'b000};

    always_comb begin
        wdata_o = wdata_i;
        wmask_o = 4'b0000;
        case (funct3_i)
            F3_B: begin
                wdata_o = {4{wdata_i[7:0]}};
                wmask_o = 4'b0001 << off_i;
            end
            F3_H: begin
                wdata_o = {2{wdata_i[15:0]}};
                wmask_o = 4'b0011 << off_i;
            end
            F3_W:    wmask_o = 4'b1111;
            default: wmask_o = 4'b0000;
        endcase
    end

    // A legal word access always has off=0, so shifted equals rdata_i there.
    always_comb begin
        load_o = 32'd0;
        case (funct3_i)
            F3_B:    load_o = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   load_o = {24'd0, shifted[7:0]};
            F3_H:    load_o = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   load_o = {16'd0, shifted[15:0]};
            F3_W:    load_o = shifted;
            default: load_o = 32'd0;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// Multicycle data-memory access stage: captures a request, runs one memory handshake
// with an optional timeout, and returns an aligned/extended result with a one-cycle pulse.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int ADDR_W  = 32
) (
    input  logic       clk,
    input  logic       rst,
    lsu_if.slave       bus,
    output lsu_state_t dbg_state_o
);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TIMEOUT);

    lsu_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        funct3_q, funct3_d;
    logic              is_store_q, is_store_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       load_data_q, load_data_d;
    logic              err_q, err_d;

    logic [31:0] al_wdata;
    logic [3:0]  al_wmask;
    logic [31:0] al_load;
    logic        in_wait;

    lsu_align u_align (
        .funct3_i (funct3_q),
        .off_i    (addr_q[1:0]),
        .wdata_i  (wdata_q),
        .rdata_i  (bus.mem_rdata),
        .wdata_o  (al_wdata),
        .wmask_o  (al_wmask),
        .load_o   (al_load)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            funct3_q    <= 3'd0;
            is_store_q  <= 1'b0;
            wdata_q     <= 32'd0;
            cnt_q       <= '0;
            load_data_q <= 32'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            funct3_q    <= funct3_d;
            is_store_q  <= is_store_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            load_data_q <= load_data_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        funct3_d    = funct3_q;
        is_store_d  = is_store_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        load_data_d = load_data_q;
        err_d       = err_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    addr_d     = bus.req_addr;
                    funct3_d   = bus.req_funct3;
                    is_store_d = bus.req_is_store;
                    wdata_d    = bus.req_wdata;
                    cnt_d      = '0;
                    if (is_legal(bus.req_is_store, bus.req_funct3, bus.req_addr[1:0])) begin
                        state_d = WAIT;
                    end else begin
                        state_d     = DONE;
                        err_d       = 1'b1;
                        load_data_d = 32'd0;
                    end
                end
            end
            WAIT: begin
                // A completion in the same cycle as the timeout limit wins over the abort.
                if (bus.mem_ready) begin
                    state_d     = DONE;
                    err_d       = 1'b0;
                    load_data_d = is_store_q ? 32'd0 : al_load;
                end else if ((TIMEOUT > 0) && (cnt_q == CNT_LAST)) begin
                    state_d     = DONE;
                    err_d       = 1'b1;
                    load_data_d = 32'd0;
                end else if (cnt_q != CNT_SAT) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign in_wait = (state_q == WAIT);

    assign bus.req_ready  = (state_q == IDLE) && !rst;
    assign bus.resp_valid = (state_q == DONE);
    assign bus.resp_err   = err_q;
    assign bus.load_data  = load_data_q;
    assign bus.mem_req    = in_wait;
    assign bus.mem_we     = in_wait && is_store_q;
    assign bus.mem_addr   = in_wait ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign bus.mem_wdata  = (in_wait && is_store_q) ? al_wdata : 32'd0;
    assign bus.mem_wmask  = (in_wait && is_store_q) ? al_wmask : 4'b0000;

    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_load_store_unit.sv
// Randomized bench for load_store_unit against a byte-addressed memory reference model.
module tb_load_store_unit;
    import lsu_pkg::*;

    localparam int TO = 4;

    logic clk = 1'b0;
    logic rst;
    lsu_state_t dbg_state;

    always #5 clk = ~clk;

    lsu_if #(.ADDR_W(32)) bus ();

    load_store_unit #(.TIMEOUT(TO), .ADDR_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus.slave),
        .dbg_state_o (dbg_state)
    );

    logic [7:0]  mem_b [0:1023];
    logic [31:0] exp_q [$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // ---------------- reference model ----------------
    function automatic int acc_size(input logic [2:0] f3);
        if (f3[1:0] == 2'd0) return 1;
        if (f3[1:0] == 2'd1) return 2;
        return 4;
    endfunction

    function automatic logic model_legal(input logic st, input logic [2:0] f3, input int addr);
        if (st && f3 > 3'd2) return 1'b0;
        if (!st && (f3 == 3'd3 || f3 >= 3'd6)) return 1'b0;
        return (addr % acc_size(f3)) == 0;
    endfunction

    function automatic logic [31:0] word_at(input int addr);
        int a;
        a = addr - (addr % 4);
        return {mem_b[a+3], mem_b[a+2], mem_b[a+1], mem_b[a]};
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input int addr);
        logic [31:0] v;
        int size;
        size = acc_size(f3);
        v = 32'd0;
        for (int i = 0; i < size; i++) v = v | (32'(mem_b[addr+i]) << (8 * i));
        if (!f3[2] && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8 * size));
        return v;
    endfunction

    task automatic model_store(input int addr, input logic [31:0] wd, input int size);
        for (int i = 0; i < size; i++) mem_b[addr+i] = wd[8*i +: 8];
    endtask

    task automatic set_word(input int addr, input logic [31:0] w);
        for (int i = 0; i < 4; i++) mem_b[addr+i] = w[8*i +: 8];
    endtask

    // ---------------- driver ----------------
    task automatic idle_inputs();
        bus.req_valid    = 1'b0;
        bus.req_is_store = 1'($urandom_range(0, 1));
        bus.req_funct3   = 3'($urandom_range(0, 7));
        bus.req_addr     = $urandom();
        bus.req_wdata    = $urandom();
        bus.mem_ready    = 1'b0;
        bus.mem_rdata    = $urandom();
    endtask

    task automatic wait_ready();
        int k;
        k = 0;
        while (!bus.req_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!bus.req_ready) check("ready_wait", 32'(bus.req_ready), 32'd1);
    endtask

    task automatic drive_req(input logic st, input logic [2:0] f3, input int addr,
                             input logic [31:0] wd);
        bus.req_valid    = 1'b1;
        bus.req_is_store = st;
        bus.req_funct3   = f3;
        bus.req_addr     = 32'(addr);
        bus.req_wdata    = wd;
    endtask

    // waits < 0 means the memory never answers.
    task automatic do_access(input logic st, input logic [2:0] f3, input int addr,
                             input logic [31:0] wd, input int waits);
        logic legal, tmo, exp_err;
        int size, ncyc;
        logic [3:0]  exp_mask;
        logic [31:0] exp_wd, exp_ld;
        legal = model_legal(st, f3, addr);
        size  = acc_size(f3);
        tmo   = legal && (waits < 0 || waits >= TO);
        exp_mask = 4'(((1 << size) - 1) << (addr % 4));
        exp_wd = (size == 1) ? {4{wd[7:0]}} : (size == 2) ? {2{wd[15:0]}} : wd;
        exp_ld = (legal && !st && !tmo) ? model_load(f3, addr) : 32'd0;
        exp_err = !legal || tmo;
        wait_ready();
        drive_req(st, f3, addr, wd);
        exp_q.push_back(exp_ld);
        @(negedge clk);
        idle_inputs();
        if (legal) begin
            ncyc = tmo ? TO : waits + 1;
            for (int i = 0; i < ncyc; i++) begin
                check("mem_req", 32'(bus.mem_req), 32'd1);
                check("mem_addr", bus.mem_addr, 32'(addr) & 32'hFFFF_FFFC);
                check("mem_we", 32'(bus.mem_we), 32'(st));
                check("mem_wmask", 32'(bus.mem_wmask), st ? 32'(exp_mask) : 32'd0);
                if (st) check("mem_wdata", bus.mem_wdata, exp_wd);
                check("early_resp", 32'(bus.resp_valid), 32'd0);
                if (!tmo && i == ncyc - 1) begin
                    bus.mem_ready = 1'b1;
                    bus.mem_rdata = word_at(addr);
                end
                @(negedge clk);
                bus.mem_ready = 1'b0;
                bus.mem_rdata = $urandom();
            end
        end
        check("resp_valid", 32'(bus.resp_valid), 32'd1);
        check("resp_err", 32'(bus.resp_err), 32'(exp_err));
        check("no_req_in_done", 32'(bus.mem_req), 32'd0);
        exp_ld = exp_q.pop_front();
        if (!st || exp_err) check("load_data", bus.load_data, exp_ld);
        if (legal && st && !tmo) model_store(addr, wd, size);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        rst = 1'b1;
        idle_inputs();
        for (int i = 0; i < 1024; i++) mem_b[i] = 8'($urandom());
        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_resp_err", 32'(bus.resp_err), 32'd0);
        check("rst_load_data", bus.load_data, 32'd0);
        check("rst_mem_req", 32'(bus.mem_req), 32'd0);
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'd0);
        check("rst_mem_wdata", bus.mem_wdata, 32'd0);
        check("rst_mem_wmask", 32'(bus.mem_wmask), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_ready", 32'(bus.req_ready), 32'd1);

        // Directed cases with hand-derived results.
        set_word(32'h100, 32'hDEADBEEF);
        do_access(1'b0, F3_W, 32'h100, 32'd0, 0);
        check("tp_lw", bus.load_data, 32'hDEADBEEF);
        set_word(32'h100, 32'h80FF1234);
        do_access(1'b0, F3_B, 32'h103, 32'd0, 0);
        check("tp_lb", bus.load_data, 32'hFFFFFF80);
        do_access(1'b0, F3_BU, 32'h103, 32'd0, 1);
        check("tp_lbu", bus.load_data, 32'h00000080);
        do_access(1'b1, F3_H, 32'h202, 32'h0000ABCD, 3);
        check("tp_sh_mem", word_at(32'h200) >> 16, 32'h0000ABCD);
        do_access(1'b0, F3_W, 32'h101, 32'd0, 0);
        check("tp_misaligned_ld", bus.load_data, 32'd0);
        do_access(1'b0, 3'd3, 32'h100, 32'd0, 0);
        do_access(1'b1, F3_BU, 32'h100, 32'd5, 0);

        // Timeout, then a request held through DONE must wait for IDLE.
        wait_ready();
        drive_req(1'b0, F3_W, 32'h108, 32'd0);
        @(negedge clk);
        idle_inputs();
        for (int i = 0; i < TO; i++) begin
            check("to_mem_req", 32'(bus.mem_req), 32'd1);
            @(negedge clk);
        end
        check("to_resp_valid", 32'(bus.resp_valid), 32'd1);
        check("to_resp_err", 32'(bus.resp_err), 32'd1);
        check("to_load_data", bus.load_data, 32'd0);
        check("to_mem_req_drop", 32'(bus.mem_req), 32'd0);
        drive_req(1'b0, F3_W, 32'h10C, 32'd0);
        @(negedge clk);
        check("b2b_ignored_req", 32'(bus.mem_req), 32'd0);
        check("b2b_idle_ready", 32'(bus.req_ready), 32'd1);
        check("b2b_no_resp", 32'(bus.resp_valid), 32'd0);
        @(negedge clk);
        idle_inputs();
        check("b2b_accepted", 32'(bus.mem_req), 32'd1);
        check("b2b_addr", bus.mem_addr, 32'h10C);
        w = word_at(32'h10C);
        bus.mem_ready = 1'b1;
        bus.mem_rdata = w;
        @(negedge clk);
        idle_inputs();
        check("b2b_resp", 32'(bus.resp_valid), 32'd1);
        check("b2b_err", 32'(bus.resp_err), 32'd0);
        check("b2b_data", bus.load_data, w);

        // Reset during the second WAIT cycle of a byte store.
        wait_ready();
        drive_req(1'b1, F3_B, 32'h205, 32'h0000_0077);
        @(negedge clk);
        idle_inputs();
        check("rw_mem_req1", 32'(bus.mem_req), 32'd1);
        @(negedge clk);
        check("rw_mem_req2", 32'(bus.mem_req), 32'd1);
        rst = 1'b1;
        check("rw_ready_in_rst", 32'(bus.req_ready), 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rw_mem_req_off", 32'(bus.mem_req), 32'd0);
            check("rw_ready_low", 32'(bus.req_ready), 32'd0);
            check("rw_no_resp", 32'(bus.resp_valid), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("rw_ready_back", 32'(bus.req_ready), 32'd1);
        check("rw_no_resp_after", 32'(bus.resp_valid), 32'd0);

        // Random traffic, biased toward aligned addresses.
        for (int n = 0; n < 60; n++) begin
            logic st;
            logic [2:0] f3;
            int addr;
            st   = 1'($urandom_range(0, 1));
            f3   = 3'($urandom_range(0, 7));
            addr = $urandom_range(0, 1023);
            if ($urandom_range(0, 3) != 0) addr = addr - (addr % acc_size(f3));
            do_access(st, f3, addr, $urandom(), $urandom_range(0, 4));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
